// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanned key matrix with per-key debounce and a one-deep event slot.
// Define KEYPAD_GHOST_MASK_EN to withhold presses that could be ghosts of three held keys.
module keypad_scanner #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 65536,
  parameter int DEBOUNCE = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [ROWS-1:0]              row_out,
  input  logic [COLS-1:0]              col_in,
  output logic [ROWS*COLS-1:0]         matrix,
  output logic                         ev_valid,
  input  logic                         ev_ready,
  output logic [((ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1)-1:0] ev_code,
  output logic                         ev_press
);

  localparam int N      = ROWS * COLS;
  localparam int CODE_W = (N > 1) ? $clog2(N) : 1;
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW     = $clog2(SCAN_DIV);
  localparam int CW     = $clog2(DEBOUNCE + 1);

  logic [RW-1:0]     row_q, row_d;
  logic [DW-1:0]     div_q, div_d;
  logic [N-1:0]      matrix_q, matrix_d;
  logic [CW-1:0]     cnt_q [N];
  logic [CW-1:0]     cnt_d [N];
  logic              ev_valid_q, ev_valid_d;
  logic [CODE_W-1:0] ev_code_q, ev_code_d;
  logic              ev_press_q, ev_press_d;

  logic              sample;
  logic [N-1:0]      elig;
  logic              found;
  logic [CODE_W-1:0] sel;

`ifdef KEYPAD_GHOST_MASK_EN
  logic [N-1:0]      ghost;

  // A press is a possible ghost when the other three corners of some rectangle are held.
  always_comb begin
    ghost = '0;
    for (int k = 0; k < N; k++) begin
      for (int r2 = 0; r2 < ROWS; r2++) begin
        for (int c2 = 0; c2 < COLS; c2++) begin
          if (r2 != k / COLS && c2 != k % COLS &&
              matrix_q[(k / COLS) * COLS + c2] &&
              matrix_q[r2 * COLS + (k % COLS)] &&
              matrix_q[r2 * COLS + c2])
            ghost[k] = 1'b1;
        end
      end
    end
  end
`endif

  always_comb begin
    sample = (div_q == DW'(SCAN_DIV - 1));
    div_d  = sample ? '0 : div_q + DW'(1);
    row_d  = row_q;
    if (sample)
      row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);

    cnt_d = cnt_q;
    elig  = '0;
    for (int k = 0; k < N; k++) begin
      if (sample && (k / COLS) == int'(row_q)) begin
        if (col_in[k % COLS] != matrix_q[k]) begin
          cnt_d[k] = (cnt_q[k] == CW'(DEBOUNCE)) ? cnt_q[k] : cnt_q[k] + CW'(1);
          elig[k]  = (cnt_d[k] == CW'(DEBOUNCE));
        end else begin
          cnt_d[k] = '0;
        end
      end
    end

`ifdef KEYPAD_GHOST_MASK_EN
    elig = elig & ~(ghost & ~matrix_q);
`endif

    found = 1'b0;
    sel   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (elig[k]) begin
        found = 1'b1;
        sel   = CODE_W'(k);
      end
    end

    matrix_d   = matrix_q;
    ev_valid_d = ev_valid_q;
    ev_code_d  = ev_code_q;
    ev_press_d = ev_press_q;
    if (ev_valid_q && ev_ready)
      ev_valid_d = 1'b0;
    // Losers keep their saturated counter and retry on the next pass of this row.
    if (found && (!ev_valid_q || ev_ready)) begin
      matrix_d[sel] = ~matrix_q[sel];
      cnt_d[sel]    = '0;
      ev_valid_d    = 1'b1;
      ev_code_d     = sel;
      ev_press_d    = ~matrix_q[sel];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q      <= '0;
      div_q      <= '0;
      matrix_q   <= '0;
      ev_valid_q <= 1'b0;
      ev_code_q  <= '0;
      ev_press_q <= 1'b0;
      for (int k = 0; k < N; k++) cnt_q[k] <= '0;
    end else begin
      row_q      <= row_d;
      div_q      <= div_d;
      matrix_q   <= matrix_d;
      ev_valid_q <= ev_valid_d;
      ev_code_q  <= ev_code_d;
      ev_press_q <= ev_press_d;
      for (int k = 0; k < N; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  always_comb begin
    row_out        = '0;
    row_out[row_q] = 1'b1;
  end

  assign matrix   = matrix_q;
  assign ev_valid = ev_valid_q;
  assign ev_code  = ev_code_q;
  assign ev_press = ev_press_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scan, debounce, backpressure and ghost masking
// on a 4x4 matrix with SCAN_DIV=4, DEBOUNCE=2.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_out;
  logic [3:0]  col_in;
  logic [15:0] matrix;
  logic        ev_valid;
  logic        ev_ready;
  logic [3:0]  ev_code;
  logic        ev_press;
  logic [15:0] raw;

  int n_chk  = 0;
  int n_fail = 0;

  keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clk(clk), .rst(rst), .row_out(row_out), .col_in(col_in), .matrix(matrix),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_press(ev_press)
  );

  always #5 clk = ~clk;

  // Physical key matrix: a closed key pulls its column high while its row is driven.
  always_comb begin
    col_in = '0;
    for (int r = 0; r < 4; r++)
      if (row_out[r]) col_in = col_in | raw[r*4 +: 4];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ev(input string tag, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!ev_valid && n < budget);
    chk({tag, "_timeout"}, 32'(ev_valid), 32'd1);
  endtask

  // Lands on the first cycle of the next dwell of row r.
  task automatic wait_row(input int r);
    int n;
    n = 0;
    while (row_out == 4'(1 << r) && n < 40) begin step(); n++; end
    while (row_out != 4'(1 << r) && n < 40) begin step(); n++; end
    chk("wait_row", 32'(row_out), 32'(1 << r));
  endtask

  task automatic pulse_ready();
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic seen;
    logic stable;
    raw      = '0;
    ev_ready = 1'b0;
    rst      = 1'b1;
    step();
    step();
    rst = 1'b0;

    chk("rst_matrix", 32'(matrix), 32'd0);
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_code", 32'(ev_code), 32'd0);
    for (int i = 0; i <= 16; i++) begin
      chk($sformatf("scan_%0d", i), 32'(row_out), 32'(1 << ((i / 4) % 4)));
      if (i < 16) step();
    end

    // Press key 9: row-2 samples at cycles 27 and 43, event visible 28 steps from cycle 16.
    raw[9] = 1'b1;
    wait_ev("press9", 60, n);
    chk("press9_latency", 32'(n), 32'd28);
    chk("press9_code", 32'(ev_code), 32'd9);
    chk("press9_press", 32'(ev_press), 32'd1);
    chk("press9_matrix", 32'(matrix), 32'h0200);
    pulse_ready();
    chk("press9_accept", 32'(ev_valid), 32'd0);

    raw[9] = 1'b0;
    wait_ev("rel9", 60, n);
    chk("rel9_code", 32'(ev_code), 32'd9);
    chk("rel9_press", 32'(ev_press), 32'd0);
    chk("rel9_matrix", 32'(matrix), 32'h0000);
    pulse_ready();

    // Bounce: closed on one row-2 sample only.
    wait_row(2);
    raw[9] = 1'b1;
    wait_row(3);
    raw[9] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin step(); seen |= ev_valid; end
    chk("bounce_no_event", 32'(seen), 32'd0);
    chk("bounce_matrix", 32'(matrix), 32'h0000);

    // Backpressure: keys 0 and 1 together, slot held.
    raw[0] = 1'b1;
    raw[1] = 1'b1;
    wait_ev("bp_first", 60, n);
    chk("bp_first_code", 32'(ev_code), 32'd0);
    chk("bp_first_press", 32'(ev_press), 32'd1);
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!ev_valid || ev_code != 4'd0 || !ev_press) stable = 1'b0;
    end
    chk("bp_hold_stable", 32'(stable), 32'd1);
    chk("bp_hold_matrix", 32'(matrix), 32'h0001);
    wait_row(2);
    pulse_ready();
    chk("bp_drop", 32'(ev_valid), 32'd0);
    wait_ev("bp_second", 60, n);
    chk("bp_second_code", 32'(ev_code), 32'd1);
    chk("bp_second_press", 32'(ev_press), 32'd1);
    chk("bp_matrix", 32'(matrix), 32'h0003);
    pulse_ready();

    // Accept on the same sample cycle that key 8 commits.
    raw[4] = 1'b1;
    raw[8] = 1'b1;
    wait_ev("sim_first", 60, n);
    chk("sim_first_code", 32'(ev_code), 32'd4);
    wait_row(2);
    step();
    step();
    step();
    chk("sim_pre_valid", 32'(ev_valid), 32'd1);
    pulse_ready();
    chk("sim_valid_cont", 32'(ev_valid), 32'd1);
    chk("sim_new_code", 32'(ev_code), 32'd8);
    chk("sim_new_press", 32'(ev_press), 32'd1);
    chk("sim_matrix", 32'(matrix), 32'h0113);
    pulse_ready();

    // Key 5 would complete a rectangle with keys 0, 1 and 4.
    raw[5]   = 1'b1;
    ev_ready = 1'b1;
    seen     = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (ev_valid && ev_code == 4'd5 && ev_press) seen = 1'b1;
    end
    ev_ready = 1'b0;
`ifdef KEYPAD_GHOST_MASK_EN
    chk("ghost_event", 32'(seen), 32'd0);
    chk("ghost_matrix5", 32'(matrix[5]), 32'd0);
`else
    chk("ghost_event", 32'(seen), 32'd1);
    chk("ghost_matrix5", 32'(matrix[5]), 32'd1);
`endif

    // Reset mid-activity with a pending event.
    raw[0] = 1'b0;
    wait_ev("rel0", 60, n);
    chk("rel0_code", 32'(ev_code), 32'd0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_valid", 32'(ev_valid), 32'd0);
    chk("rst2_matrix", 32'(matrix), 32'd0);
    chk("rst2_row", 32'(row_out), 32'd1);
    chk("rst2_code", 32'(ev_code), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
